i2c_cfg_responder: RTL and testbench

I2C write-target that terminates the three-byte configuration transfers (device address, register address, data) issued by the board's audio/video configuration sequencer. It oversamples the open-drain SCL/SDA lines with the system clock, acknowledges transfers addressed to its device address, and presents each received register/data pair as a one-cycle write strobe. It stands in for the codec in simulation and in loopback builds, and serves as the target side for any on-chip register bank configured over I2C.

---
 rtl/i2c_cfg_responder_if.sv | 59 +++++
 rtl/i2c_cfg_responder.sv | 261 ++++++++++++++++++++++++++
 tb/tb_i2c_cfg_responder.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_cfg_responder_if.sv
// ---------------------------------------------------------------------------
// i2c_cfg_responder_if
//
// This interface groups the pin-level and register-write signals of the I2C
// configuration responder.
//
// Signals:
//   scl_in, sda_in    SCL and SDA pin levels. They are asynchronous to clk.
//   sda_oe            1 = the responder pulls SDA low. 0 = SDA is released.
//   wr_en             One-cycle write strobe.
//   wr_addr, wr_data  Register address and data that go with wr_en.
//   busy              High while a transfer addressed to this target is open.
//   rd_addr, rd_data  Read port. These exist only when I2C_READ_EN is defined.
//
// Modports:
//   slave   The responder side.
//   master  The side that drives the bus and consumes the writes.
// ---------------------------------------------------------------------------
interface i2c_cfg_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
`ifdef I2C_READ_EN
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
`endif

    modport slave (
        input  scl_in,
        input  sda_in,
        output sda_oe,
        output wr_en,
        output wr_addr,
        output wr_data,
`ifdef I2C_READ_EN
        output rd_addr,
        input  rd_data,
`endif
        output busy
    );

    modport master (
        output scl_in,
        output sda_in,
        input  sda_oe,
        input  wr_en,
        input  wr_addr,
        input  wr_data,
`ifdef I2C_READ_EN
        input  rd_addr,
        output rd_data,
`endif
        input  busy
    );
endinterface

// File: rtl/i2c_cfg_responder.sv
// ---------------------------------------------------------------------------
// i2c_cfg_responder
//
// This block is an I2C write target for three-byte configuration transfers:
// device address, then register address, then data. It oversamples SCL and
// SDA with clk. It ACKs transfers sent to DEV_ADDR. Each received data byte
// is issued as a one-cycle write strobe. The register pointer auto-increments,
// so further data bytes in the same transfer go to the following registers.
//
// Ports:
//   clk    System clock. It must run at least 8x the SCL rate.
//   reset  Asynchronous, active-low reset.
//   bus    i2c_cfg_responder_if.slave. It carries:
//            - the SCL/SDA pin levels,
//            - the SDA pull-down enable,
//            - the write strobe with its address and data,
//            - busy,
//            - the optional read port.
//
// Optional feature, macro I2C_READ_EN:
//   When defined, address byte {DEV_ADDR,1} starts a read. The responder
//   then shifts out rd_data for rd_addr = pointer. The pointer advances on
//   each controller ACK.
//   When undefined, read requests are ignored and are not ACKed.
// ---------------------------------------------------------------------------
module i2c_cfg_responder #(
    parameter logic [6:0] DEV_ADDR = 7'h1A
) (
    input  logic               clk,
    input  logic               reset,
    i2c_cfg_responder_if.slave bus
);
    typedef enum logic [3:0] {
        IDLE,
        DEV,
        DEV_ACK,
        REG,
        REG_ACK,
        DATA,
        DATA_ACK,
        IGNORE,
        TX,
        TX_ACK
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] bit_cnt_reg, bit_cnt_next;
    logic [6:0] shift_reg, shift_next;    // the 7 bits before the current sample
    logic [7:0] ptr_reg, ptr_next;
    logic       sda_oe_reg, sda_oe_next;
    logic       wr_en_reg, wr_en_next;
    logic [7:0] wr_addr_reg, wr_addr_next;
    logic [7:0] wr_data_reg, wr_data_next;

    // Pin conditioning. Bit 1 is SCL and bit 0 is SDA.
    // The path is: two synchronizer flops, then one history flop for edges.
    logic [1:0] pin_meta_reg, pin_sync_reg, pin_hist_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            // Reset to the idle (released) bus level. This prevents a false
            // edge when the block comes out of reset.
            pin_meta_reg <= 2'b11;
            pin_sync_reg <= 2'b11;
            pin_hist_reg <= 2'b11;
        end else begin
            pin_meta_reg <= {bus.scl_in, bus.sda_in};
            pin_sync_reg <= pin_meta_reg;
            pin_hist_reg <= pin_sync_reg;
        end
    end

    logic scl_s, scl_d, sda_s, sda_d;
    logic scl_rise, scl_fall, start_det, stop_det, last_bit;
    logic [7:0] byte_in;

    assign scl_s = pin_sync_reg[1];
    assign scl_d = pin_hist_reg[1];
    assign sda_s = pin_sync_reg[0];
    assign sda_d = pin_hist_reg[0];

    assign scl_rise = scl_s & ~scl_d;
    assign scl_fall = ~scl_s & scl_d;

    // START and STOP need SCL high in both samples.
    // If SCL and SDA move in the same sample, it counts as a clock edge.
    assign start_det = scl_s & scl_d & sda_d & ~sda_s;
    assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

    assign byte_in  = {shift_reg, sda_s};
    assign last_bit = (bit_cnt_reg == 4'd7);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 4'd0;
            shift_reg   <= 7'd0;
            ptr_reg     <= 8'd0;
            sda_oe_reg  <= 1'b0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= 8'd0;
            wr_data_reg <= 8'd0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            ptr_reg     <= ptr_next;
            sda_oe_reg  <= sda_oe_next;
            wr_en_reg   <= wr_en_next;
            wr_addr_reg <= wr_addr_next;
            wr_data_reg <= wr_data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        ptr_next     = ptr_reg;
        sda_oe_next  = sda_oe_reg;
        wr_en_next   = 1'b0;
        wr_addr_next = wr_addr_reg;
        wr_data_next = wr_data_reg;

        if (start_det) begin
            // A repeated START drops any partial byte.
            state_next   = DEV;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
        end else if (stop_det) begin
            state_next   = IDLE;
            bit_cnt_next = 4'd0;
            sda_oe_next  = 1'b0;
        end else begin
            case (state_reg)
                IDLE, IGNORE: begin
                    sda_oe_next = 1'b0;
                end

                DEV, REG, DATA: begin
                    if (scl_rise) begin
                        shift_next   = byte_in[6:0];
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                        if (last_bit) begin
                            case (state_reg)
                                DEV: begin
                                    if (byte_in[7:1] == DEV_ADDR && !byte_in[0])
                                        state_next = DEV_ACK;
`ifdef I2C_READ_EN
                                    else if (byte_in[7:1] == DEV_ADDR)
                                        state_next = DEV_ACK;
`endif
                                    else
                                        state_next = IGNORE;
                                end
                                REG: begin
                                    ptr_next   = byte_in;
                                    state_next = REG_ACK;
                                end
                                default: begin
                                    wr_en_next   = 1'b1;
                                    wr_addr_next = ptr_reg;
                                    wr_data_next = byte_in;
                                    state_next   = DATA_ACK;
                                end
                            endcase
                        end
                    end
                end

                // The ACK states are entered on the 8th rising edge.
                // sda_oe itself marks the ACK phase:
                //   - the first falling edge starts the ACK (drive SDA low),
                //   - the next falling edge, after the 9th clock, ends it.
                DEV_ACK, REG_ACK, DATA_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_reg) begin
                            sda_oe_next = 1'b1;
                        end else begin
                            sda_oe_next  = 1'b0;
                            bit_cnt_next = 4'd0;
                            case (state_reg)
                                DEV_ACK: begin
`ifdef I2C_READ_EN
                                    // shift_reg[0] still holds the R/W bit.
                                    if (shift_reg[0]) begin
                                        state_next  = TX;
                                        sda_oe_next = ~bus.rd_data[7];
                                    end else
`endif
                                    state_next = REG;
                                end
                                REG_ACK: state_next = DATA;
                                default: begin
                                    ptr_next   = ptr_reg + 8'd1;
                                    state_next = DATA;
                                end
                            endcase
                        end
                    end
                end

`ifdef I2C_READ_EN
                // bit_cnt counts the bits the controller has sampled.
                // The next bit is driven on each falling edge.
                TX: begin
                    if (scl_rise) begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt_reg == 4'd8) begin
                            sda_oe_next = 1'b0;
                            state_next  = TX_ACK;
                        end else begin
                            sda_oe_next = ~bus.rd_data[3'd7 - bit_cnt_reg[2:0]];
                        end
                    end
                end

                // The pointer advances on the ACK rising edge. This gives
                // rd_data time to settle for the new address before the
                // first bit is driven on the following falling edge.
                // bit_cnt = 9 means "ACK seen".
                TX_ACK: begin
                    if (scl_rise) begin
                        if (!sda_s) begin
                            ptr_next     = ptr_reg + 8'd1;
                            bit_cnt_next = 4'd9;
                        end else begin
                            state_next = IGNORE;
                        end
                    end else if (scl_fall && bit_cnt_reg == 4'd9) begin
                        bit_cnt_next = 4'd0;
                        sda_oe_next  = ~bus.rd_data[7];
                        state_next   = TX;
                    end
                end
`endif

                default: begin
                    state_next  = IDLE;
                    sda_oe_next = 1'b0;
                end
            endcase
        end
    end

    assign bus.sda_oe  = sda_oe_reg;
    assign bus.wr_en   = wr_en_reg;
    assign bus.wr_addr = wr_addr_reg;
    assign bus.wr_data = wr_data_reg;
    assign bus.busy    = (state_reg == DEV_ACK) || (state_reg == REG) ||
                         (state_reg == REG_ACK) || (state_reg == DATA) ||
                         (state_reg == DATA_ACK)
`ifdef I2C_READ_EN
                         || (state_reg == TX) || (state_reg == TX_ACK)
`endif
                         ;
`ifdef I2C_READ_EN
    assign bus.rd_addr = ptr_reg;
`endif
endmodule

// File: tb/tb_i2c_cfg_responder.sv
// ---------------------------------------------------------------------------
// tb_i2c_cfg_responder
//
// This bench is a behavioural I2C controller. It drives transfers at the
// byte level, both directed and random.
//
// A transfer-level model predicts two things from the address and payload:
//   - the ACK expected for each byte,
//   - the sequence of register writes.
//
// Observed ACKs and wr_en pulses are compared with that model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_i2c_cfg_responder;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    int   q_clks = 5;          // clk cycles per quarter SCL period
    int   err_cnt = 0;
    int   chk_cnt = 0;

    logic [15:0] obs_wr[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  model_ptr = 8'd0;
    logic [7:0]  xb[8];
    bit          exp_ack_a[8];
    bit          oe_seen = 1'b0;
    bit          busy_seen = 1'b0;

    i2c_cfg_responder_if bus_if();

    i2c_cfg_responder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #10 clk = ~clk;     // 50 MHz

    // SDA is open-drain: the line is low if either side pulls it low.
    assign bus_if.scl_in = scl_drv;
    assign bus_if.sda_in = sda_drv & ~bus_if.sda_oe;

`ifdef I2C_READ_EN
    logic [7:0] rd_mem[256];
    assign bus_if.rd_data = rd_mem[bus_if.rd_addr];
`endif

    always @(negedge clk) begin
        if (reset && bus_if.wr_en) obs_wr.push_back({bus_if.wr_addr, bus_if.wr_data});
        if (bus_if.sda_oe) oe_seen = 1'b1;
        if (bus_if.busy) busy_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wq();
        repeat (q_clks) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b0; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic write_bit(input logic b);
        sda_drv = b; wq();
        scl_drv = 1'b1; wq(); wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic sample_bit(output logic v);
        sda_drv = 1'b1; wq();
        scl_drv = 1'b1; wq();
        v = bus_if.sda_in; wq();
        scl_drv = 1'b0; wq();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) write_bit(b[i]);
        sample_bit(v);
        ack = ~v;
    endtask

    task automatic read_byte(output logic [7:0] d, input logic ack);
        logic v;
        for (int i = 7; i >= 0; i--) begin
            sample_bit(v);
            d[i] = v;
        end
        write_bit(~ack);
    endtask

    // When timed is set, busy must still be high 2 clk after SDA rises and
    // low 3 clk after it rises.
    task automatic i2c_stop(input bit timed);
        sda_drv = 1'b0; wq();
        scl_drv = 1'b1; wq();
        sda_drv = 1'b1;
        if (timed) begin
            repeat (2) @(negedge clk);
            check("busy_before_stop_seen", 32'(bus_if.busy), 32'd1);
            @(negedge clk);
            check("busy_after_stop", 32'(bus_if.busy), 32'd0);
        end
        wq(); wq();
    endtask

    // Transfer-level reference model of a write transfer in xb[0..n-1]:
    //   - Only the 0x34 write address is ACKed, and then every byte is ACKed.
    //   - The second byte loads the pointer.
    //   - Each later byte writes (pointer, byte), then the pointer wraps +1.
    task automatic model_xfer(input int n);
        bit acc;
        acc = (xb[0] == 8'h34);
        for (int i = 0; i < n; i++) exp_ack_a[i] = acc;
        if (acc) begin
            for (int i = 1; i < n; i++) begin
                if (i == 1) model_ptr = xb[1];
                else begin
                    exp_wr.push_back({model_ptr, xb[i]});
                    model_ptr = model_ptr + 8'd1;
                end
            end
        end
    endtask

    task automatic compare_writes();
        check("wr_count", 32'(obs_wr.size()), 32'(exp_wr.size()));
        while (obs_wr.size() > 0 && exp_wr.size() > 0)
            check("wr_pair", 32'(obs_wr.pop_front()), 32'(exp_wr.pop_front()));
        obs_wr.delete();
        exp_wr.delete();
    endtask

    task automatic do_xfer(input int n, input int tail_bits, input bit timed);
        logic ack;
        bit   acc;
        acc = (xb[0] == 8'h34);
        model_xfer(n);
        obs_wr.delete();
        oe_seen = 1'b0;
        busy_seen = 1'b0;
        i2c_start();
        for (int i = 0; i < n; i++) begin
            write_byte(xb[i], ack);
            check("ack", 32'(ack), 32'(exp_ack_a[i]));
        end
        for (int i = 0; i < tail_bits; i++) write_bit(1'($urandom_range(0, 1)));
        i2c_stop(timed && acc);
        repeat (4) @(negedge clk);
        check("sda_oe_seen", 32'(oe_seen), 32'(acc));
        check("busy_seen", 32'(busy_seen && n > 1), 32'(acc && n > 1));
        check("busy_idle", 32'(bus_if.busy), 32'd0);
        compare_writes();
        $display("xfer addr=%02h bytes=%0d tail=%0d checks=%0d errors=%0d",
                 xb[0], n, tail_bits, chk_cnt, err_cnt);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;

`ifdef I2C_READ_EN
        for (int i = 0; i < 256; i++) rd_mem[i] = 8'($urandom_range(0, 255));
        rd_mem[8'h1A] = 8'hA5;
        rd_mem[8'h1B] = 8'hA5;
`endif
        repeat (5) @(negedge clk);
        check("rst_sda_oe", 32'(bus_if.sda_oe), 32'd0);
        check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
        check("rst_wr_addr", 32'(bus_if.wr_addr), 32'd0);
        check("rst_wr_data", 32'(bus_if.wr_data), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
`ifdef I2C_READ_EN
        check("rst_rd_addr", 32'(bus_if.rd_addr), 32'd0);
`endif
        reset = 1'b1;
        repeat (5) @(negedge clk);

        // 100 kHz transfer with busy-fall timing.
        q_clks = 125;
        xb[0] = 8'h34; xb[1] = 8'h0C; xb[2] = 8'h00;
        do_xfer(3, 0, 1'b1);
        q_clks = 5;

        // Foreign address: no ACK, no write, never busy.
        xb[0] = 8'h40; xb[1] = 8'h12; xb[2] = 8'h34;
        do_xfer(3, 0, 1'b0);

`ifndef I2C_READ_EN
        // Read request without read support: ignored.
        xb[0] = 8'h35; xb[1] = 8'h12; xb[2] = 8'h56;
        do_xfer(3, 0, 1'b0);
`endif

        // Pointer wrap.
        xb[0] = 8'h34; xb[1] = 8'hFF; xb[2] = 8'hAA; xb[3] = 8'h55;
        do_xfer(4, 0, 1'b1);

        // Repeated START after 4 bits of a data byte.
        obs_wr.delete();
        i2c_start();
        write_byte(8'h34, ack); check("rs_ack_dev", 32'(ack), 32'd1);
        write_byte(8'h20, ack); check("rs_ack_reg", 32'(ack), 32'd1);
        model_ptr = 8'h20;
        for (int i = 0; i < 4; i++) write_bit(1'($urandom_range(0, 1)));
        check("rs_no_partial_wr", 32'(obs_wr.size()), 32'd0);
        xb[0] = 8'h34; xb[1] = 8'h12; xb[2] = 8'h01;
        do_xfer(3, 0, 1'b0);

        // Reset while the device-address ACK is being driven.
        i2c_start();
        for (int i = 7; i >= 0; i--) write_bit(logic'(i == 5 || i == 4 || i == 2));
        check("ack_drive", 32'(bus_if.sda_oe), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_release_sda", 32'(bus_if.sda_oe), 32'd0);
        check("rst_busy_mid", 32'(bus_if.busy), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        model_ptr = 8'd0;
        sample_bit(ack);
        check("rst_no_ack", 32'(ack), 32'd1);
        i2c_stop(1'b0);
        xb[0] = 8'h34; xb[1] = 8'h08; xb[2] = 8'hF8;
        do_xfer(3, 0, 1'b0);

`ifdef I2C_READ_EN
        // Set the pointer, repeated START, read two bytes (ACK then NACK).
        i2c_start();
        write_byte(8'h34, ack); check("rd_ack_dev_w", 32'(ack), 32'd1);
        write_byte(8'h1A, ack); check("rd_ack_reg", 32'(ack), 32'd1);
        model_ptr = 8'h1A;
        i2c_start();
        write_byte(8'h35, ack); check("rd_ack_dev_r", 32'(ack), 32'd1);
        check("rd_addr0", 32'(bus_if.rd_addr), 32'(model_ptr));
        read_byte(d, 1'b1);
        check("rd_byte0", 32'(d), 32'(rd_mem[model_ptr]));
        model_ptr = model_ptr + 8'd1;
        check("rd_addr1", 32'(bus_if.rd_addr), 32'(model_ptr));
        read_byte(d, 1'b0);
        check("rd_byte1", 32'(d), 32'(rd_mem[model_ptr]));
        check("rd_addr_nack", 32'(bus_if.rd_addr), 32'(model_ptr));
        oe_seen = 1'b0;
        for (int i = 0; i < 9; i++) write_bit(1'b0);
        check("rd_ignore_oe", 32'(oe_seen), 32'd0);
        i2c_stop(1'b0);
        check("rd_busy_idle", 32'(bus_if.busy), 32'd0);
        $display("read xfer ptr=1A bytes=2 checks=%0d errors=%0d", chk_cnt, err_cnt);
`endif

        // Random transfers.
        for (int t = 0; t < 12; t++) begin
            int n;
            int tail;
            n = int'($urandom_range(1, 5));
            tail = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            if ($urandom_range(0, 3) != 0) xb[0] = 8'h34;
            else begin
                xb[0] = 8'($urandom_range(0, 255));
                while (xb[0] == 8'h34 || xb[0] == 8'h35) xb[0] = 8'($urandom_range(0, 255));
            end
            for (int i = 1; i < 8; i++) xb[i] = 8'($urandom_range(0, 255));
            do_xfer(n, tail, 1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end
endmodule
